sdram_read_arbiter: RTL and testbench
=====================================

// Module: sdram_read_arbiter
// PURPOSE
//  Round-robin arbiter and burst sequencer that shares the single Avalon-MM SDRAM read master among NUM_PORTS EU fetch engines.
//  It replaces static CU-driven port selection; it sits between the EU groups' fetch units and the SDRAM read port.
//  One burst is outstanding at a time.
//  Return data is broadcast; a per-port valid qualifies it.
// PARAMETERS
//  NUM_PORTS  8    number of requesters (>=2)
//  DATA_W     128  SDRAM read data width
//  ADDR_W     32   byte address width
//  BURST_W    8    burstcount width (max burst 2**BURST_W-1)
// PORTS
//  clk              in   1                    clock
//  rst              in   1                    synchronous, active-high reset
//  req              in   NUM_PORTS            per-port read request, held until matching done
//  req_addr         in   NUM_PORTS*ADDR_W     per-port start address, port i at [i*ADDR_W +: ADDR_W]
//  req_burst        in   NUM_PORTS*BURST_W    per-port beat count, port i at [i*BURST_W +: BURST_W]
//  gnt              out  NUM_PORTS            one-hot owner of the read port, 0 when idle
//  rdata            out  DATA_W               = avm_readdata (broadcast)
//  rdata_valid      out  NUM_PORTS            avm_readdatavalid routed to owner bit only
//  done             out  NUM_PORTS            1-cycle pulse to owner on last beat
//  busy             out  1                    state != IDLE
//  avm_address      out  ADDR_W               latched owner address
//  avm_read         out  1                    read command
//  avm_burstcount   out  BURST_W              latched owner burst
//  avm_waitrequest  in   1                    slave stall
//  avm_readdata     in   DATA_W               slave data
//  avm_readdatavalid in  1                    slave data valid
// BEHAVIOUR
//  Reset:
//   - state=IDLE; gnt, avm_read, done and rdata_valid are 0.
//   - avm_address and avm_burstcount are 0.
//   - RR pointer last=NUM_PORTS-1, so port 0 has top priority after reset.
//  FSM:
//   - IDLE: if |req, pick the first requesting port searching last+1, last+2, ... (mod NUM_PORTS).
//     Register owner, addr and burst (0 is coerced to 1). Set gnt[owner]. Go to CMD.
//   - CMD: avm_read=1, address and burstcount stable.
//     On an edge with avm_read && !avm_waitrequest, drop avm_read, clear beat counter, go to DATA.
//   - DATA: each avm_readdatavalid sets rdata_valid[owner]=1 combinationally in the same cycle and increments the counter.
//     On the beat where count == burst-1: done[owner]=1 in that same cycle.
//     Next cycle: state=IDLE, gnt=0, last=owner.
//  Latency:
//   - req rising in IDLE gives gnt and avm_read on the next cycle.
//   - Earliest re-grant is the cycle after the last beat; minimum one IDLE cycle between bursts.
//  Boundary conditions:
//   - Changes to req, req_addr or req_burst after grant are ignored. A req drop mid-burst does not abort the burst.
//   - avm_readdatavalid outside DATA is ignored: no valid, no count. Any late beats after reset are dropped.
//   - Simultaneous requests: strict RR. With N ports continuously requesting, each port gets exactly one burst per N grants.
//   - Reset mid-burst: return to reset state next cycle, gnt and avm_read drop immediately. The slave's pending beats are discarded.
//   - Max burst 2**BURST_W-1; the counter is BURST_W bits wide and never wraps.
//  Assertions:
//   - gnt is $onehot0.
//   - avm_read implies state==CMD.
//   - While avm_waitrequest, avm_address and avm_burstcount are stable.
//   - done implies rdata_valid on the same bit.
// TESTING
//  1 req[2]=1, addr 0x100, burst 4, waitrequest 0, valids on 4 consecutive cycles -> gnt=0x04 next cycle.
//    avm_read high for 1 cycle at 0x100/4; rdata_valid=0x04 x4; done[2] on the 4th beat; gnt=0 after.
//  2 req[0] and req[3] asserted in the same cycle, burst 1 each, out of reset -> port 0 served, then port 3.
//    Next req[0]+req[3] after that -> port 0 again, since last=3.
//  3 All 8 ports hold req, burst 2 -> grant order 0,1,...,7,0; no port granted twice within 8 grants.
//  4 waitrequest held high 3 cycles in CMD -> avm_read held 4 cycles; address/burstcount constant; data phase starts after acceptance.
//  5 rst pulsed after 2 of 8 beats -> gnt/avm_read 0 next cycle; the 6 remaining slave beats give no rdata_valid.
//    Next req[5] -> granted normally.
//  6 burst=0 on port 1 -> avm_burstcount=1; done[1] on the first beat.
//    Gaps in readdatavalid -> valid only on valid cycles; count correct.

Source files
------------

// File: rtl/sdram_read_arbiter_if.sv
// rtl/sdram_read_arbiter_if.sv - Avalon-MM burst read port shared by the EU fetch arbiter.
interface sdram_read_arbiter_if #(
  parameter int DATA_W  = 128,
  parameter int ADDR_W  = 32,
  parameter int BURST_W = 8
);
  logic [ADDR_W-1:0]  avm_address;
  logic               avm_read;
  logic [BURST_W-1:0] avm_burstcount;
  logic               avm_waitrequest;
  logic [DATA_W-1:0]  avm_readdata;
  logic               avm_readdatavalid;

  modport master (
    output avm_address,
    output avm_read,
    output avm_burstcount,
    input  avm_waitrequest,
    input  avm_readdata,
    input  avm_readdatavalid
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    input  avm_burstcount,
    output avm_waitrequest,
    output avm_readdata,
    output avm_readdatavalid
  );
endinterface

// File: rtl/sdram_read_arbiter.sv
// rtl/sdram_read_arbiter.sv - Round-robin arbiter and burst sequencer for the shared SDRAM read master.
// One burst in flight; read data is broadcast and qualified per port.
module sdram_read_arbiter #(
  parameter int NUM_PORTS = 8,
  parameter int DATA_W    = 128,
  parameter int ADDR_W    = 32,
  parameter int BURST_W   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          req,
  input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
  input  logic [NUM_PORTS*BURST_W-1:0]  req_burst,
  output logic [NUM_PORTS-1:0]          gnt,
  output logic [DATA_W-1:0]             rdata,
  output logic [NUM_PORTS-1:0]          rdata_valid,
  output logic [NUM_PORTS-1:0]          done,
  output logic                          busy,
  sdram_read_arbiter_if.master          avm
);
  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;

  logic [ADDR_W-1:0]  addr_arr  [NUM_PORTS];
  logic [BURST_W-1:0] burst_arr [NUM_PORTS];

  logic                 beat;
  logic                 last_beat;
  logic [NUM_PORTS-1:0] owner_oh;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign burst_arr[g] = req_burst[g*BURST_W +: BURST_W];
  end

  // Beats are only honoured in DATA, so stale slave data after a reset is dropped.
  assign beat      = (state_q == DATA) && avm.avm_readdatavalid;
  assign last_beat = beat && (cnt_q == (burst_q - BURST_W'(1)));
  assign owner_oh  = NUM_PORTS'(1) << owner_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_PORTS - 1);
      addr_q  <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    int               t;
    logic             found;
    logic [IDX_W-1:0] cand;
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    t       = 0;
    found   = 1'b0;
    cand    = '0;
    case (state_q)
      IDLE: begin
        // Search starts just after the previous owner, wrapping round.
        for (int off = 1; off <= NUM_PORTS; off++) begin
          t = int'(last_q) + off;
          if (t >= NUM_PORTS) t = t - NUM_PORTS;
          cand = IDX_W'(t);
          if (!found && req[cand]) begin
            found   = 1'b1;
            owner_d = cand;
          end
        end
        if (found) begin
          addr_d  = addr_arr[owner_d];
          burst_d = (burst_arr[owner_d] == '0) ? BURST_W'(1) : burst_arr[owner_d];
          state_d = CMD;
        end
      end
      CMD: begin
        if (!avm.avm_waitrequest) begin
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (beat) cnt_d = cnt_q + BURST_W'(1);
        if (last_beat) begin
          state_d = IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt                = '0;
    rdata_valid        = '0;
    done               = '0;
    busy               = (state_q != IDLE);
    avm.avm_read       = (state_q == CMD);
    avm.avm_address    = addr_q;
    avm.avm_burstcount = burst_q;
    rdata              = avm.avm_readdata;
    if (state_q != IDLE) gnt = owner_oh;
    if (beat)            rdata_valid = owner_oh;
    if (last_beat)       done = owner_oh;
  end

  a_gnt_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_read_in_cmd : assert property (@(posedge clk) disable iff (rst) avm.avm_read |-> (state_q == CMD));
  a_cmd_stable : assert property (@(posedge clk) disable iff (rst)
    (avm.avm_read && avm.avm_waitrequest) |=> ($stable(avm.avm_address) && $stable(avm.avm_burstcount)));
  a_done_valid : assert property (@(posedge clk) disable iff (rst) ((done & rdata_valid) == done));
endmodule

// File: tb/tb_sdram_read_arbiter.sv
// tb/tb_sdram_read_arbiter.sv - Directed self-checking bench for sdram_read_arbiter.
module tb_sdram_read_arbiter;
  localparam int NP = 8;
  localparam int DW = 128;
  localparam int AW = 32;
  localparam int BW = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [NP-1:0]      req;
  logic [NP*AW-1:0]   req_addr;
  logic [NP*BW-1:0]   req_burst;
  logic [NP-1:0]      gnt;
  logic [DW-1:0]      rdata;
  logic [NP-1:0]      rdata_valid;
  logic [NP-1:0]      done;
  logic               busy;

  int vectors = 0;
  int errs    = 0;

  sdram_read_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .BURST_W(BW)) avm_if ();

  sdram_read_arbiter #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .BURST_W(BW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_addr    (req_addr),
    .req_burst   (req_burst),
    .gnt         (gnt),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .done        (done),
    .busy        (busy),
    .avm         (avm_if)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic [31:0] a, input logic [7:0] b);
    req_addr[p*AW +: AW]  = a;
    req_burst[p*BW +: BW] = b;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    req = '0;
    avm_if.avm_readdatavalid = 1'b0;
    avm_if.avm_waitrequest   = 1'b0;
    #3;
    chk("rst_gnt", gnt, 0);
    chk("rst_read", avm_if.avm_read, 0);
    chk("rst_addr", avm_if.avm_address, 0);
    chk("rst_bc", avm_if.avm_burstcount, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rv", rdata_valid, 0);
    chk("rst_done", done, 0);
  endtask

  // Entered from an IDLE cycle with req already set; returns in the following IDLE cycle.
  task automatic serve(input int p, input logic [31:0] a, input logic [7:0] bc, input int beats,
                       input bit clr, input int nwait, input int gap, input bit spur);
    logic [31:0]  sa;
    logic [7:0]   sb;
    logic [7:0]   oh;
    logic [127:0] rd;
    oh = 8'(1 << p);
    sa = req_addr[p*AW +: AW];
    sb = req_burst[p*BW +: BW];
    avm_if.avm_waitrequest = (nwait > 0);
    tick;
    for (int w = 0; w <= nwait; w++) begin
      if (w > 0) tick;
      avm_if.avm_waitrequest   = (w < nwait);
      avm_if.avm_readdatavalid = spur;
      if (w == 0) begin
        set_port(p, ~sa, ~sb);
        if (clr) req[p] = 1'b0;
      end
      #3;
      chk($sformatf("gnt_p%0d", p), gnt, oh);
      chk("cmd_read", avm_if.avm_read, 1);
      chk("cmd_addr", avm_if.avm_address, a);
      chk("cmd_bc", avm_if.avm_burstcount, bc);
      chk("cmd_no_rv", rdata_valid, 0);
    end
    tick;
    avm_if.avm_waitrequest = 1'b0;
    for (int i = 0; i < beats; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          avm_if.avm_readdatavalid = 1'b0;
          #3;
          chk("gap_rv", rdata_valid, 0);
          chk("gap_done", done, 0);
          tick;
        end
      end
      rd = {64'hC0DE_0000_0000_0000, 32'(p), 32'(i)};
      avm_if.avm_readdatavalid = 1'b1;
      avm_if.avm_readdata      = rd;
      #3;
      chk("data_read", avm_if.avm_read, 0);
      chk("data_rv", rdata_valid, oh);
      chk("data_done", done, (i == beats - 1) ? oh : 8'h00);
      chk("data_rdata", rdata, rd);
      tick;
    end
    avm_if.avm_readdatavalid = 1'b0;
    set_port(p, sa, sb);
    #3;
    chk("end_gnt", gnt, 0);
    chk("end_busy", busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    req_addr = '0;
    req_burst = '0;
    avm_if.avm_waitrequest   = 1'b0;
    avm_if.avm_readdata      = '0;
    avm_if.avm_readdatavalid = 1'b0;

    // 1: single port, burst of 4 back-to-back beats
    do_reset;
    set_port(2, 32'h100, 8'd4);
    req = 8'h04;
    #1;
    chk("t1_idle_gnt", gnt, 0);
    serve(2, 32'h100, 8'd4, 4, 1, 0, 0, 0);

    // 2: simultaneous requests resolved round-robin from reset
    do_reset;
    set_port(0, 32'h0A0, 8'd1);
    set_port(3, 32'h3A0, 8'd1);
    req = 8'h09;
    serve(0, 32'h0A0, 8'd1, 1, 1, 0, 0, 0);
    serve(3, 32'h3A0, 8'd1, 1, 1, 0, 0, 0);
    req = 8'h09;
    serve(0, 32'h0A0, 8'd1, 1, 1, 0, 0, 0);
    serve(3, 32'h3A0, 8'd1, 1, 1, 0, 0, 0);

    // 3: all ports requesting continuously
    do_reset;
    for (int p = 0; p < NP; p++) set_port(p, 32'h1000 * p + 32'h40, 8'd2);
    req = 8'hFF;
    for (int p = 0; p < NP; p++) serve(p, 32'h1000 * p + 32'h40, 8'd2, 2, 0, 0, 0, 0);
    serve(0, 32'h40, 8'd2, 2, 0, 0, 0, 0);
    req = '0;

    // 4: slave stalls the command, spurious valids ignored outside DATA
    set_port(6, 32'h600, 8'd2);
    req = 8'h40;
    serve(6, 32'h600, 8'd2, 2, 1, 3, 0, 1);

    // 5: reset in the middle of an 8-beat burst
    set_port(7, 32'h700, 8'd8);
    req = 8'h80;
    tick;
    #3;
    chk("t5_gnt", gnt, 8'h80);
    chk("t5_read", avm_if.avm_read, 1);
    tick;
    for (int i = 0; i < 2; i++) begin
      avm_if.avm_readdatavalid = 1'b1;
      #3;
      chk("t5_rv", rdata_valid, 8'h80);
      tick;
    end
    avm_if.avm_readdatavalid = 1'b0;
    rst = 1'b1;
    req = '0;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      avm_if.avm_readdatavalid = 1'b1;
      #3;
      chk("t5_post_gnt", gnt, 0);
      chk("t5_post_read", avm_if.avm_read, 0);
      chk("t5_post_rv", rdata_valid, 0);
      chk("t5_post_done", done, 0);
      if (i == 0) begin
        chk("t5_post_busy", busy, 0);
        chk("t5_post_addr", avm_if.avm_address, 0);
      end
      tick;
    end
    avm_if.avm_readdatavalid = 1'b0;
    set_port(5, 32'h500, 8'd3);
    req = 8'h20;
    #3;
    serve(5, 32'h500, 8'd3, 3, 1, 0, 0, 0);

    // 6: zero burst coerced to one, then a burst with gaps between beats
    set_port(1, 32'h2000, 8'd0);
    req = 8'h02;
    serve(1, 32'h2000, 8'd1, 1, 1, 0, 0, 0);
    set_port(4, 32'h4440, 8'd3);
    req = 8'h10;
    serve(4, 32'h4440, 8'd3, 3, 1, 0, 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
